mcb_port_sequencer: RTL

Sequences a single 64-bit memory-controller user port (the p0 command, write-FIFO and read-FIFO group) on behalf of one host-side requester.
- Holds off all traffic until calibration is complete.
- Turns each host burst request into the correct sequence: write-FIFO fill, then command strobe; or command strobe, then read-FIFO drain.
- Guards against read-data stalls with a timeout.
- Sits between the host/application logic and the DDR interface wrapper, in the c3_clk0 domain.

---
 rtl/mcb_seq_pkg.sv | 16 +
 rtl/mcb_port_sequencer_sync2.sv | 24 ++
 rtl/mcb_port_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mcb_seq_pkg.sv
// Shared encodings for the MCB port sequencer: FSM states and MCB command opcodes.
package mcb_seq_pkg;

  typedef enum logic [2:0] {
    CALIB_WAIT = 3'd0,
    IDLE       = 3'd1,
    WR_FILL    = 3'd2,
    WR_CMD     = 3'd3,
    RD_CMD     = 3'd4,
    RD_DRAIN   = 3'd5
  } state_e;

  localparam logic [2:0] INSTR_WRITE = 3'b000;
  localparam logic [2:0] INSTR_READ  = 3'b001;

endpackage

// File: rtl/mcb_port_sequencer_sync2.sv
// Two-flop synchroniser; both stages clear to 0 on reset.
module sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic s1_q, s2_q;

  // Shift the asynchronous input through two stages.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/mcb_port_sequencer.sv
// Sequences one MCB user port (p0 cmd / wr / rd FIFOs) for a single host requester.
// Data-path strobes are combinational pass-throughs so a word moves in the same
// cycle it is offered; command fields come straight from the latched request.
module mcb_port_sequencer
  import mcb_seq_pkg::*;
#(
  parameter int MAX_WORDS  = 64,
  parameter int RD_TIMEOUT = 4095,
  parameter int ADDR_W     = 30
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              calib_done_raw,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [5:0]        req_len,
  input  logic [63:0]       wdata,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [63:0]       rdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic              busy,
  output logic              calib_ok,
  output logic              err_timeout,
  output logic              p0_cmd_en,
  output logic [2:0]        p0_cmd_instr,
  output logic [5:0]        p0_cmd_bl,
  output logic [ADDR_W-1:0] p0_cmd_byte_addr,
  input  logic              p0_cmd_full,
  output logic              p0_wr_en,
  output logic [63:0]       p0_wr_data,
  output logic [7:0]        p0_wr_mask,
  input  logic              p0_wr_full,
  output logic              p0_rd_en,
  input  logic [63:0]       p0_rd_data,
  input  logic              p0_rd_empty
);

  // Counter holds MAX_WORDS itself so a full 64-word burst never wraps.
  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam int TMO_W = $clog2(RD_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [5:0]        len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              push, pop, last;

  sync2 u_calib_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (calib_done_raw),
    .q       (calib_ok)
  );

  assign last = (cnt_q == CNT_W'(len_q));

  // Next-state and same-cycle handshakes; everything is held off while calibration is down.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    err_d        = err_q;
    req_ready    = 1'b0;
    wdata_ready  = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    p0_cmd_en    = 1'b0;
    p0_cmd_instr = INSTR_WRITE;
    p0_wr_data   = '0;
    rdata        = '0;
    if (!calib_ok) begin
      // Losing calibration abandons any burst without a command strobe.
      state_d = CALIB_WAIT;
    end else begin
      case (state_q)
        CALIB_WAIT: state_d = IDLE;
        IDLE: begin
          req_ready = 1'b1;
          if (req_valid) begin
            addr_d  = req_addr & ~ADDR_W'(7);
            len_d   = req_len;
            cnt_d   = '0;
            state_d = req_write ? WR_FILL : RD_CMD;
          end
        end
        WR_FILL: begin
          wdata_ready = ~p0_wr_full;
          push        = wdata_valid & ~p0_wr_full;
          p0_wr_data  = wdata;
          if (push) begin
            cnt_d = cnt_q + 1'b1;
            if (last) state_d = WR_CMD;
          end
        end
        WR_CMD: begin
          if (!p0_cmd_full) begin
            p0_cmd_en = 1'b1;
            state_d   = IDLE;
          end
        end
        RD_CMD: begin
          p0_cmd_instr = INSTR_READ;
          if (!p0_cmd_full) begin
            p0_cmd_en = 1'b1;
            cnt_d     = '0;
            tmo_d     = '0;
            state_d   = RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          pop   = ~p0_rd_empty & rdata_ready;
          rdata = p0_rd_data;
          if (pop) begin
            cnt_d = cnt_q + 1'b1;
            tmo_d = '0;
            if (last) state_d = IDLE;
          end else begin
            // Leftover FIFO words are left in place when the drain gives up.
            tmo_d = tmo_q + 1'b1;
            if (tmo_d == TMO_W'(RD_TIMEOUT)) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = CALIB_WAIT;
      endcase
    end
    busy_d = (state_d != IDLE) && (state_d != CALIB_WAIT);
  end

  // State and request registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= CALIB_WAIT;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign busy             = busy_q;
  assign err_timeout      = err_q;
  assign p0_wr_en         = push;
  assign p0_wr_mask       = '0;
  assign p0_rd_en         = pop;
  assign rdata_valid      = pop;
  assign p0_cmd_bl        = len_q;
  assign p0_cmd_byte_addr = addr_q;

endmodule
